// File: rtl/load_store_unit.sv
// Load/store unit: turns RISC-V byte/half/word accesses into word-aligned, byte-masked memory transactions.
// Optional misalignment trap is enabled by defining MISALIGNED_TRAP_EN.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [6:0]  OP_LOAD      = 7'b0000011;
    localparam logic [6:0]  OP_STORE     = 7'b0100011;
    localparam bit          TIMEOUT_ON   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state;
    logic [1:0]  addr_lo;
    logic [2:0]  funct3_q;
    logic [31:0] timeout_count;

    logic        accept;
    logic        is_store;
    logic        f3_valid;
    logic [3:0]  store_mask;
    logic [31:0] store_wdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign busy     = (state != IDLE);
    assign is_store = (opcode == OP_STORE);
    assign accept   = start && (opcode == OP_LOAD || opcode == OP_STORE);
    // funct3[1:0] encodes the access size; 011, 110 and 111 have no meaning here.
    assign f3_valid = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);

`ifdef MISALIGNED_TRAP_EN
    logic misaligned;
    assign misaligned = ((funct3[1:0] == 2'b01) && address[0]) ||
                        ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
`endif

    always_comb begin
        store_mask  = 4'b1111;
        store_wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                store_mask  = 4'b0001 << address[1:0];
                store_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                store_mask  = 4'b0011 << {address[1], 1'b0};
                store_wdata = {2{store_data[15:0]}};
            end
            default: begin
                store_mask  = 4'b1111;
                store_wdata = store_data;
            end
        endcase
    end

    // Lane selection uses the offset captured at accept, not the live address input.
    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_ext = 32'h0;
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_ext = mem_rdata;
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            addr_lo       <= 2'b00;
            funct3_q      <= 3'b000;
            timeout_count <= 32'h0;
            done          <= 1'b0;
            bus_error     <= 1'b0;
            load_data     <= 32'h0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'h0;
            mem_wdata     <= 32'h0;
            mem_wmask     <= 4'b0000;
        end else begin
            done      <= 1'b0;
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_lo       <= address[1:0];
                        funct3_q      <= funct3;
                        timeout_count <= 32'h0;
                        if (!f3_valid) begin
                            load_data <= 32'h0;
                            done      <= 1'b1;
                            state     <= RESP;
`ifdef MISALIGNED_TRAP_EN
                        end else if (misaligned) begin
                            load_data <= 32'h0;
                            done      <= 1'b1;
                            bus_error <= 1'b1;
                            state     <= RESP;
`endif
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {address[31:2], 2'b00};
                            mem_wdata <= is_store ? store_wdata : 32'h0;
                            mem_wmask <= is_store ? store_mask : 4'b0000;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    // An ack in the final allowed cycle still completes normally.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            load_data <= load_ext;
                        end
                        done  <= 1'b1;
                        state <= RESP;
                    end else if (TIMEOUT_ON && timeout_count == TIMEOUT_LAST) begin
                        mem_req   <= 1'b0;
                        load_data <= 32'h0;
                        done      <= 1'b1;
                        bus_error <= 1'b1;
                        state     <= RESP;
                    end else begin
                        timeout_count <= timeout_count + 32'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scoreboard of expected completions, fixed-cycle handshake checks.
// Expectations for the misaligned case follow MISALIGNED_TRAP_EN when it is defined.
module tb_load_store_unit;

    localparam int         TIMEOUT  = 4;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        bus_error;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          check_data;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .opcode     (opcode),
        .funct3     (funct3),
        .address    (address),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .bus_error  (bus_error),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=still_running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step;
        @(negedge clk);
    endtask

    // Drives a one-cycle start; returns at the negedge of the first cycle after accept.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        start = 1'b1; opcode = op; funct3 = f3; address = addr; store_data = wd;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] data, input logic err, input bit chk);
        exp_t e;
        e.data = data; e.err = err; e.check_data = chk;
        sb_q.push_back(e);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; opcode = 7'h0; funct3 = 3'h0;
        address = 32'h0; store_data = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++;
        if ({busy, done, mem_req, bus_error, mem_wmask} !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_ctrl actual=%b required=00000000", {busy, done, mem_req, bus_error, mem_wmask});
        end
        checks++;
        if ({load_data, mem_addr, mem_wdata} !== 96'h0) begin
            failures++;
            $display("[TB] FAIL reset_data actual=%h required=0", {load_data, mem_addr, mem_wdata});
        end
    endtask

    task automatic test_store_byte;
        exp_t e;
        issue(OP_STORE, 3'b000, 32'h0000_1003, 32'h0000_00A5);
        push_exp(32'h0, 1'b0, 1'b0);
        checks++;
        if ({mem_req, mem_we, mem_wmask} !== 6'b11_1000) begin
            failures++;
            $display("[TB] FAIL sb_ctrl actual=%b required=111000", {mem_req, mem_we, mem_wmask});
        end
        checks++;
        if (mem_addr !== 32'h0000_1000 || mem_wdata !== 32'hA5A5_A5A5) begin
            failures++;
            $display("[TB] FAIL sb_bus actual=%h/%h required=00001000/a5a5a5a5", mem_addr, mem_wdata);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sb_done actual=%b required=1", done);
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bus_error !== e.err) begin
                failures++;
                $display("[TB] FAIL sb_result actual_err=%b required_err=%b", bus_error, e.err);
            end
        end
        step();
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL sb_idle actual=%b required=00", {done, busy});
        end
    endtask

    task automatic test_store_half;
        exp_t e;
        issue(OP_STORE, 3'b001, 32'h0000_0402, 32'hCAFE_BEEF);
        push_exp(32'h0, 1'b0, 1'b0);
        checks++;
        if (mem_wmask !== 4'b1100 || mem_wdata !== 32'hBEEF_BEEF || mem_addr !== 32'h0000_0400) begin
            failures++;
            $display("[TB] FAIL sh_bus actual=%b/%h/%h required=1100/beefbeef/00000400", mem_wmask, mem_wdata, mem_addr);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sh_done actual=%b required=1", done);
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bus_error !== e.err) begin
                failures++;
                $display("[TB] FAIL sh_result actual_err=%b required_err=%b", bus_error, e.err);
            end
        end
    endtask

    task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp_data, input string name);
        exp_t e;
        int   req_ok = 0;
        mem_rdata = 32'h00F0_0000;
        issue(OP_LOAD, f3, 32'h0000_2002, 32'hFFFF_FFFF);
        push_exp(exp_data, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (mem_req === 1'b1 && mem_we === 1'b0 && mem_wmask === 4'b0000 && mem_addr === 32'h0000_2000 && done === 1'b0)
                req_ok++;
            if (i == 3) mem_ack = 1'b1;
            step();
        end
        mem_ack = 1'b0;
        checks++;
        if (req_ok != 4) begin
            failures++;
            $display("[TB] FAIL %s_req_hold actual=%0d required=4", name, req_ok);
        end
        checks++;
        if (done !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_done actual=%b%b required=10", name, done, mem_req);
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bus_error !== e.err || (e.check_data && load_data !== e.data)) begin
                failures++;
                $display("[TB] FAIL %s_result actual=%h/%b required=%h/%b", name, load_data, bus_error, e.data, e.err);
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   done_count = 0;
        int   req_seen   = 0;
        mem_rdata = 32'h8001_0000;
        issue(OP_LOAD, 3'b001, 32'h0000_0006, 32'h0);
        push_exp(32'hFFFF_8001, 1'b0, 1'b1);
        start = 1'b1; opcode = OP_STORE; funct3 = 3'b010; address = 32'h0000_5000;
        step();
        start = 1'b0;
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h0000_0004 || mem_req !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hs_busy_start actual=%b/%h/%b required=0/00000004/1", mem_we, mem_addr, mem_req);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        start = 1'b1; opcode = OP_LOAD; funct3 = 3'b010; address = 32'h0000_6000;
        if (done === 1'b1) begin
            done_count++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (bus_error !== e.err || (e.check_data && load_data !== e.data)) begin
                    failures++;
                    $display("[TB] FAIL hs_result actual=%h/%b required=%h/%b", load_data, bus_error, e.data, e.err);
                end
            end
        end
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) done_count++;
            if (mem_req === 1'b1 || busy === 1'b1) req_seen++;
            step();
        end
        checks++;
        if (done_count != 1) begin
            failures++;
            $display("[TB] FAIL hs_done_count actual=%0d required=1", done_count);
        end
        checks++;
        if (req_seen != 0) begin
            failures++;
            $display("[TB] FAIL hs_ignored_start actual=%0d required=0", req_seen);
        end
    endtask

    task automatic test_timeout;
        exp_t e;
        int   req_cnt = 0;
        int   late    = 0;
        issue(OP_LOAD, 3'b010, 32'h0000_7000, 32'h0);
        push_exp(32'h0, 1'b1, 1'b1);
        for (int i = 0; i < TIMEOUT; i++) begin
            if (mem_req === 1'b1 && done === 1'b0) req_cnt++;
            step();
        end
        checks++;
        if (req_cnt != TIMEOUT) begin
            failures++;
            $display("[TB] FAIL to_req_cycles actual=%0d required=%0d", req_cnt, TIMEOUT);
        end
        checks++;
        if (done !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL to_done actual=%b%b required=10", done, mem_req);
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bus_error !== e.err || (e.check_data && load_data !== e.data)) begin
                failures++;
                $display("[TB] FAIL to_result actual=%h/%b required=%h/%b", load_data, bus_error, e.data, e.err);
            end
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done === 1'b1 || busy === 1'b1 || mem_req === 1'b1) late++;
            step();
        end
        checks++;
        if (late != 0) begin
            failures++;
            $display("[TB] FAIL to_late_ack actual=%0d required=0", late);
        end
    endtask

    task automatic test_misaligned;
        exp_t e;
        mem_rdata = 32'h1234_5678;
        issue(OP_LOAD, 3'b010, 32'h0000_3001, 32'h0);
`ifdef MISALIGNED_TRAP_EN
        push_exp(32'h0, 1'b1, 1'b1);
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mis_no_req actual=%b required=0", mem_req);
        end
`else
        push_exp(32'h1234_5678, 1'b0, 1'b1);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_3000) begin
            failures++;
            $display("[TB] FAIL mis_bus actual=%b/%h required=1/00003000", mem_req, mem_addr);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
`endif
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mis_done actual=%b required=1", done);
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bus_error !== e.err || (e.check_data && load_data !== e.data)) begin
                failures++;
                $display("[TB] FAIL mis_result actual=%h/%b required=%h/%b", load_data, bus_error, e.data, e.err);
            end
        end
    endtask

    task automatic test_invalid;
        exp_t e;
        mem_rdata = 32'h5555_AAAA;
        issue(OP_LOAD, 3'b011, 32'h0000_0010, 32'h0);
        push_exp(32'h0, 1'b0, 1'b1);
        checks++;
        if (mem_req !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL inv_f3 actual=%b%b required=01", mem_req, done);
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bus_error !== e.err || (e.check_data && load_data !== e.data)) begin
                failures++;
                $display("[TB] FAIL inv_f3_result actual=%h/%b required=%h/%b", load_data, bus_error, e.data, e.err);
            end
        end
        step();
        issue(7'b0110011, 3'b010, 32'h0000_0020, 32'h0);
        checks++;
        if ({busy, done, mem_req} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL inv_opcode actual=%b required=000", {busy, done, mem_req});
        end
    endtask

    task automatic test_reset_mid;
        int late = 0;
        issue(OP_LOAD, 3'b010, 32'h0000_8000, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, mem_req, mem_addr} !== 34'h0) begin
            failures++;
            $display("[TB] FAIL rst_mid actual=%b/%b/%h required=0/0/00000000", busy, mem_req, mem_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done === 1'b1 || busy === 1'b1) late++;
            step();
        end
        checks++;
        if (late != 0) begin
            failures++;
            $display("[TB] FAIL rst_mid_ack actual=%0d required=0", late);
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_store_half();
        test_load_byte(3'b000, 32'hFFFF_FFF0, "lb");
        test_load_byte(3'b100, 32'h0000_00F0, "lbu");
        test_back_to_back();
        test_timeout();
        test_misaligned();
        test_invalid();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Consumer of the effective address produced for LOAD/STORE opcodes.
- Accepts one access request from the execute stage and converts byte/half/word RISC-V semantics into a word-aligned, byte-masked data-memory transaction with a req/ack handshake.
- Holds busy until the memory acknowledges, then returns the aligned and sign/zero-extended load result with a one-cycle done pulse.
- Sits between the address generator / execute stage and the data-memory port.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles mem_req may wait for mem_ack before the access is aborted; 0 disables the timeout.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  access request from the execute stage; sampled only in IDLE
- opcode  input  7  instruction opcode; only LOAD 7'b0000011 and STORE 7'b0100011 are accepted
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- address  input  32  effective byte address (rs1 + immediate)
- store_data  input  32  rs2 value for stores
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse when the access completes or aborts
- load_data  output  32  extended load result; valid while done = 1
- bus_error  output  1  one-cycle pulse together with done on timeout or misalignment trap
- mem_req  output  1  memory request; held until acknowledged
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  32  {address[31:2], 2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_wmask  output  4  byte-enable mask; 4'b0000 on reads
- mem_ack  input  1  memory acknowledge; read data is valid in the same cycle
- mem_rdata  input  32  memory read word

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State returns to IDLE.
  - All outputs clear to 0, including load_data, mem_addr, mem_wdata and mem_wmask.
  - Timeout counter clears.
  - Reset mid-transaction abandons the access; an mem_ack arriving afterwards is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Accept when start = 1 and opcode is LOAD or STORE.
  - On accept, register address[1:0], funct3 and the direction, then drive mem_addr, mem_we, mem_wdata and mem_wmask, and set mem_req = 1. Go to REQ.
  - Any other opcode, or start = 0, leaves the unit in IDLE with no output change.
  - Invalid funct3 (011, 110, 111): no bus transaction is issued; go to RESP with load_data = 0 and bus_error = 0.
- REQ:
  - mem_req and all mem_* fields remain stable until mem_ack = 1.
  - On mem_ack: drop mem_req; for loads, register the extended mem_rdata into load_data. Go to RESP.
  - Timeout counter increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES: drop mem_req, set load_data = 0, pulse bus_error, go to RESP.
  - If mem_ack arrives in the same cycle the counter reaches TIMEOUT_CYCLES, mem_ack wins.
- RESP: done = 1 for exactly one cycle, then return to IDLE. A start in this cycle is ignored.
- Latency: start at cycle 0 gives mem_req from cycle 1; the earliest mem_ack is in cycle 1, which gives done in cycle 2.
- start while busy is ignored and not queued.
- Store lane rules:
  - SB: mask = 4'b0001 << addr[1:0]; wdata = {4{store_data[7:0]}}.
  - SH: mask = 4'b0011 << {addr[1], 1'b0}; wdata = {2{store_data[15:0]}}.
  - SW: mask = 4'b1111; wdata = store_data.
- Load extraction uses the registered addr[1:0]:
  - LB / LBU select byte addr[1:0], then sign- or zero-extend.
  - LH / LHU select halfword addr[1], then sign- or zero-extend.
  - LW passes mem_rdata unchanged.
- Misaligned access without the optional feature: the address is word-aligned by mem_addr, and lane selection uses addr[1:0] as given. SH at offset 3 therefore uses the mask shift from addr[1] only, and no error is raised.

Optional Feature:
- MISALIGNED_TRAP_EN defined:
  - In IDLE, an accepted access is misaligned if it is H/HU with addr[0] = 1, or W with addr[1:0] != 0.
  - A misaligned access issues no mem_req, goes directly to RESP, sets load_data = 0, and raises bus_error together with done.
- MISALIGNED_TRAP_EN undefined: no alignment check; behaviour as stated under Behaviour.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles, then release -> busy, done, mem_req and bus_error are 0; mem_wmask = 0.
- SB: address = 0x1003, store_data = 0xA5 -> mem_addr = 0x1000, mem_wmask = 4'b1000, mem_wdata = 0xA5A5A5A5, mem_we = 1. With mem_ack in cycle 1, done pulses in cycle 2 with bus_error = 0.
- LB / LBU: address = 0x2002, mem_rdata = 0x00F00000 with ack after 3 wait cycles -> LB gives load_data = 0xFFFFFFF0 and LBU gives 0x000000F0. mem_req is held stable for 4 cycles.
- Handshake: LH at address 0x0006, mem_rdata = 0x80010000 -> load_data = 0xFFFF8001. A start pulsed while busy is ignored, and exactly one done is produced.
- Timeout: TIMEOUT_CYCLES = 4, never ack -> mem_req drops after 4 REQ cycles; done and bus_error pulse together; load_data = 0. A late ack is ignored.
- Misalignment: LW at address 0x3001 -> with MISALIGNED_TRAP_EN, no mem_req and done + bus_error in cycle 1; without it, mem_addr = 0x3000 and a normal completion.
